// File: rtl/seq_addsub_unit_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width: clog2(width/digit), never narrower than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_addsub_unit_if.sv
// Start/done request bus between the operand registers and the add/sub unit.
// Latency: none (wires only).
// Backpressure: start is only honoured while the unit is idle (busy low).
interface seq_addsub_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op_sub, a, b, cin,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op_sub, a, b, cin,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/seq_addsub_unit_digit_slice_add.sv
// DIGIT-bit ripple adder built from full-adder cells; exposes MSB carry-in for overflow.
// Latency: combinational.
// Backpressure: none.
module digit_slice_add #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);
    logic [DIGIT:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[DIGIT];
    assign cmsb_o = c[DIGIT-1];
endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/subtract, DIGIT bits per clock LSB first. Optional macro: SEQ_ADDSUB_SATURATE_EN.
// Latency: done pulses WIDTH/DIGIT+1 cycles after the start is accepted.
// Backpressure: start ignored while busy; results held until the next accepted start.
module seq_addsub_unit
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_addsub_unit_if.slave      bus_if
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_sh_q, res_sh_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [DIGIT-1:0]       slice_sum;
    logic                   slice_cout;
    logic                   slice_cmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic [WIDTH-1:0]       res_final;
    logic                   ovf_raw;

    digit_slice_add #(.DIGIT(DIGIT)) u_slice (
        .a_i    (a_sh_q[DIGIT-1:0]),
        .b_i    (b_sh_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout),
        .cmsb_o (slice_cmsb)
    );

    // New digit enters at the MSB end; after N steps the word is fully aligned.
    assign res_cat  = {slice_sum, res_sh_q};
    assign res_next = WIDTH'(res_cat >> DIGIT);
    assign ovf_raw  = slice_cmsb ^ slice_cout;

`ifdef SEQ_ADDSUB_SATURATE_EN
    // Overflow flips the sign bit, so the wrapped sign tells which limit to clamp to.
    assign res_final = ovf_raw ? {~res_next[WIDTH-1], {(WIDTH-1){res_next[WIDTH-1]}}}
                               : res_next;
`else
    assign res_final = res_next;
`endif

    // State and datapath registers, cleared on async reset (aborts any operation).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state and datapath steering: capture in IDLE, one digit per RUN cycle.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.start) begin
                    a_sh_d   = bus_if.a;
                    b_sh_d   = bus_if.op_sub ? ~bus_if.b : bus_if.b;
                    carry_d  = bus_if.op_sub ? 1'b1 : bus_if.cin;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                res_sh_d = res_next;
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = res_final;
                    cout_d   = slice_cout;
                    ovf_d    = ovf_raw;
                    zero_d   = (res_final == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_if.busy   = (state_q != ST_IDLE);
    assign bus_if.done   = (state_q == ST_DONE);
    assign bus_if.result = result_q;
    assign bus_if.cout   = cout_q;
    assign bus_if.ovf    = ovf_q;
    assign bus_if.zero   = zero_q;
endmodule

// File: doc/seq_addsub_unit.md
Name: seq_addsub_unit

Overview:
Parametrised multi-cycle adder/subtractor for the calculator datapath. It is the sequential successor to the fixed 8-bit ripple adder.
- Processes DIGIT bits per clock through a small ripple slice, LSB digit first.
- Width and digit size are generic; adds subtract mode, a start/done handshake and status flags.
- Sits between the operand registers and the display/result mux.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT, ≥2.
DIGIT, 2, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op_sub  in  1  0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored).
a  in  WIDTH  operand A, captured on accepted start.
b  in  WIDTH  operand B, captured on accepted start.
cin  in  1  carry-in for add, captured on accepted start.
busy  out  1  high from accepted start until done cycle inclusive.
done  out  1  one-cycle pulse, result valid.
result  out  WIDTH  sum/difference, held until next accepted start.
cout  out  1  carry out; for subtract, 1 = no borrow (a ≥ b unsigned).
ovf  out  1  signed two's-complement overflow.
zero  out  1  result == 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, result, cout, ovf, zero all 0; internal counters and shift registers cleared. Reset mid-operation aborts the operation; no done pulse.
- N = WIDTH/DIGIT digit steps.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: on edge with start=1:
  - capture a into a_sh.
  - capture b into b_sh, inverted when op_sub=1.
  - carry <= op_sub ? 1 : cin; cnt <= 0; busy <= 1; go RUN.
- RUN: each edge:
  - DIGIT-bit slice adds a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry.
  - Slice sum shifted into the MSB end of the result shift register; a_sh and b_sh shift right by DIGIT.
  - carry <= slice carry-out; cnt++.
  - On step cnt = N-1: capture final carry as cout; ovf = carry into MSB XOR carry out of MSB, taken from inside the last slice; go DONE.
- DONE: done=1, busy=1 for exactly one cycle; result, cout, ovf and zero registered valid; go IDLE.
- Latency: start accepted at edge E0; digits processed at E1..EN; done high in the cycle after EN. For WIDTH=8, DIGIT=2: done is seen 5 cycles after the start cycle.
- start while RUN/DONE is ignored, not queued.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE (back-to-back, one op per N+2 cycles).
- Outputs change only on accepted-operation completion or reset. result is not updated during RUN; the shift register is internal.
- DIGIT = WIDTH: N=1; single-step behaviour is otherwise identical.

Optional Feature:
SEQ_ADDSUB_SATURATE_EN
- Defined: when ovf=1, result is clamped to the signed limit:
  - 0111..1 if the operands were non-negative (add) or a≥0 > b (sub);
  - 1000..0 otherwise.
  - ovf still reports 1; zero is computed on the clamped value.
- Undefined: result wraps modulo 2^WIDTH.

Decomposition:
- Package seq_addsub_pkg holds:
  - FSM state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Helper function for the counter width, clog2(WIDTH/DIGIT) with minimum 1.
- One sub-module digit_slice_add:
  - combinational DIGIT-bit ripple adder built from full-adder cells;
  - outputs sum, carry-out, and carry into its MSB (for ovf).

Test Plan:
- WIDTH=8, DIGIT=2, add a=100, b=27, cin=0 -> done in 5th cycle after start, result=127, cout=0, ovf=0, zero=0.
- add a=0x7F, b=0x01 -> result=0x80, ovf=1, cout=0. With SEQ_ADDSUB_SATURATE_EN: result=0x7F, ovf=1.
- sub a=5, b=7 -> result=0xFE, cout=0 (borrow), ovf=0. Sub a=7, b=7 -> result=0, zero=1, cout=1.
- add a=200, b=100, cin=1 -> result=45, cout=1, ovf=0.
- Pulse start again 2 cycles into RUN with different operands -> ignored, first result unchanged, exactly one done pulse.
- Drop rst_n for 1 cycle mid-RUN -> all outputs 0 immediately, no done; new start afterwards completes normally.
- Sweep DIGIT ∈ {1,2,4,8} at WIDTH=8, and WIDTH=16 with DIGIT=4, using random operands -> result matches a±b and done latency = N+1 cycles.
